register_feed_fifo: RTL and testbench

//  Paced source stage that feeds the register slice directly downstream.
//  - Buffers words from an upstream producer in a DEPTH-entry synchronous FIFO.
//  - Drives the slice's enable/data pair as registered outputs, so they wire straight in.
//  - Emits at most one word per GAP+1 cycles; downstream backpressure via hold.

---
 rtl/register_feed_fifo_if.sv | 46 ++++
 rtl/register_feed_fifo.sv | 116 +++++++++++
 tb/tb_register_feed_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/register_feed_fifo_if.sv
// ---------------------------------------------------------------------------
// register_feed_fifo_if
//   Bundle between an upstream producer / downstream register slice and the
//   register_feed_fifo stage.
//   master : the environment side (drives push/push_data/hold, observes rest)
//   slave  : the register_feed_fifo side
//   Signals:
//     push, push_data  upstream write strobe and word
//     full, empty      FIFO status, combinational from occupancy
//     hold             downstream backpressure
//     enable, data     registered strobe/word pair for the register slice
//     level            FIFO occupancy
//     overflow         sticky dropped-push flag (REGISTER_FEED_OVF_EN only)
// ---------------------------------------------------------------------------
interface register_feed_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                     push;
    logic [WIDTH-1:0]         push_data;
    logic                     full;
    logic                     empty;
    logic                     hold;
    logic                     enable;
    logic [WIDTH-1:0]         data;
    logic [$clog2(DEPTH):0]   level;
`ifdef REGISTER_FEED_OVF_EN
    logic                     overflow;
`endif

    modport master (
        output push, push_data, hold,
        input  full, empty, enable, data, level
`ifdef REGISTER_FEED_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  push, push_data, hold,
        output full, empty, enable, data, level
`ifdef REGISTER_FEED_OVF_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/register_feed_fifo.sv
// ---------------------------------------------------------------------------
// register_feed_fifo
//   Paced source stage feeding a downstream register slice. Words from an
//   upstream producer are buffered in a DEPTH-entry synchronous FIFO and
//   emitted as a registered enable/data pair, at most one word per GAP+1
//   cycles, with downstream backpressure via hold.
//   Ports:
//     clk      single clock, posedge
//     reset_n  asynchronous active-low reset; discards FIFO contents
//     bus      register_feed_fifo_if.slave (push/push_data/full/empty/hold/
//              enable/data/level[/overflow])
//   Parameters: WIDTH (data width), DEPTH (power of 2, >= 2), GAP (idle
//   cycles forced after each emitted word).
//   Optional feature: define REGISTER_FEED_OVF_EN to add the sticky
//   bus.overflow flag, set by any push attempted while full.
// ---------------------------------------------------------------------------
module register_feed_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    register_feed_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, READY, PACE, STALL} state_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    count, count_next;
    logic [GW-1:0]    gap_cnt, gap_next;
    logic             push_acc, pop;
    state_t           state, state_next;

    assign bus.full  = (count == LW'(DEPTH));
    assign bus.empty = (count == '0);
    assign bus.level = count;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_acc   = bus.push && !bus.full;
    assign pop        = !bus.empty && !bus.hold && (gap_cnt == '0);
    assign count_next = count + LW'(push_acc) - LW'(pop);

    // Pacing counter reloads on every emitted word and counts down regardless of hold.
    always_comb begin
        gap_next = gap_cnt;
        if (pop)
            gap_next = GW'(GAP);
        else if (gap_cnt != '0)
            gap_next = gap_cnt - GW'(1);
    end

    // Storage is not reset; validity is tracked entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (push_acc)
            mem[wr_ptr] <= bus.push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gap_cnt    <= '0;
            bus.enable <= 1'b0;
            bus.data   <= '0;
        end else begin
            count   <= count_next;
            gap_cnt <= gap_next;
            if (push_acc)
                wr_ptr <= wr_ptr + AW'(1);   // wraps modulo DEPTH (power of 2)
            if (pop) begin
                bus.data   <= mem[rd_ptr];
                bus.enable <= 1'b1;
                rd_ptr     <= rd_ptr + AW'(1);
            end else begin
                bus.enable <= 1'b0;
            end
        end
    end

`ifdef REGISTER_FEED_OVF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.overflow <= 1'b0;
        else if (bus.push && bus.full)
            bus.overflow <= 1'b1;
    end
`endif

    // Status tracker. It describes the stage after the coming edge and never
    // feeds back into the datapath, so it adds no latency. STALL predicts from
    // the hold level currently presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (count_next == '0)
            state_next = IDLE;
        else if (gap_next != '0)
            state_next = PACE;
        else if (bus.hold)
            state_next = STALL;
        else
            state_next = READY;
    end
endmodule

// File: tb/tb_register_feed_fifo.sv
// ---------------------------------------------------------------------------
// tb_register_feed_fifo
//   Two instances (GAP=0 and GAP=2, WIDTH=8, DEPTH=4) share one input stream.
//   A queue-based reference model per instance predicts every output after
//   each edge; directed steps add constant expectations for the key cases.
// ---------------------------------------------------------------------------
module tb_register_feed_fifo;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       push_i;
    logic [7:0] din;
    logic       hold_i;

    int n_assert = 0;
    int n_fail   = 0;

    register_feed_fifo_if #(.WIDTH(8), .DEPTH(4)) if0 ();
    register_feed_fifo_if #(.WIDTH(8), .DEPTH(4)) if1 ();

    assign if0.push = push_i;  assign if0.push_data = din;  assign if0.hold = hold_i;
    assign if1.push = push_i;  assign if1.push_data = din;  assign if1.hold = hold_i;

    register_feed_fifo #(.WIDTH(8), .DEPTH(4), .GAP(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    register_feed_fifo #(.WIDTH(8), .DEPTH(4), .GAP(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    always #5 clk = ~clk;

    // Reference model: FIFO as a queue, pacing as a plain down-counter.
    logic [7:0] mq [2][$];
    int         mgc  [2];
    logic       men  [2];
    logic [7:0] mdat [2];
    logic       movf [2];

    function automatic int gap_of(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mgc[k] = 0; men[k] = 1'b0; mdat[k] = 8'h00; movf[k] = 1'b0;
        end
    endtask

    task automatic model_edge(int k);
        bit was_full;
        bit do_pop;
        was_full = (mq[k].size() == 4);
        do_pop   = (mq[k].size() != 0) && !hold_i && (mgc[k] == 0);
        if (push_i && was_full) movf[k] = 1'b1;
        if (do_pop) begin
            mdat[k] = mq[k].pop_front();
            men[k]  = 1'b1;
            mgc[k]  = gap_of(k);
        end else begin
            men[k] = 1'b0;
            if (mgc[k] > 0) mgc[k]--;
        end
        if (push_i && !was_full) mq[k].push_back(din);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(int k, logic en, logic [7:0] d, logic [2:0] lvl, logic f, logic e);
        chk($sformatf("u%0d.enable", k), 32'(en),  32'(men[k]));
        chk($sformatf("u%0d.data", k),   32'(d),   32'(mdat[k]));
        chk($sformatf("u%0d.level", k),  32'(lvl), 32'(mq[k].size()));
        chk($sformatf("u%0d.full", k),   32'(f),   32'(mq[k].size() == 4));
        chk($sformatf("u%0d.empty", k),  32'(e),   32'(mq[k].size() == 0));
    endtask

    task automatic check_all();
        chk_dut(0, if0.enable, if0.data, if0.level, if0.full, if0.empty);
        chk_dut(1, if1.enable, if1.data, if1.level, if1.full, if1.empty);
`ifdef REGISTER_FEED_OVF_EN
        chk("u0.overflow", 32'(if0.overflow), 32'(movf[0]));
        chk("u1.overflow", 32'(if1.overflow), 32'(movf[1]));
`endif
    endtask

    task automatic step(logic p, logic [7:0] d, logic h);
        push_i = p; din = d; hold_i = h;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; push_i = 1'b0; din = 8'h00; hold_i = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("reset.enable", 32'(if0.enable), 32'd0);
        chk("reset.level",  32'(if0.level),  32'd0);
        @(negedge clk) reset_n = 1'b1;

        // single word, GAP=0: no bypass, one-cycle strobe
        step(1'b1, 8'h11, 1'b0);
        chk("t1.level_after_push", 32'(if0.level),  32'd1);
        chk("t1.no_bypass",        32'(if0.enable), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1.enable", 32'(if0.enable), 32'd1);
        chk("t1.data",   32'(if0.data),   32'h11);
        chk("t1.level0", 32'(if0.level),  32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("t1.enable_drop", 32'(if0.enable), 32'd0);
        chk("t1.data_held",   32'(if0.data),   32'h11);

        // fill under hold, drop the fifth push, then drain back-to-back
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b1);
            if (i == 3) chk("t2.full", 32'(if0.full), 32'd1);
        end
        chk("t2.level4", 32'(if0.level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("t2.enable", 32'(if0.enable), 32'd1);
            chk("t2.data",   32'(if0.data),   32'hA0 + 32'(i));
        end
        chk("t2.empty", 32'(if0.empty), 32'd1);
        idle(15);

        // GAP=2 pacing on u1
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("t3.enable", 32'(if1.enable), 32'(i % 3 == 0));
            chk("t3.data",   32'(if1.data),   32'(i / 3 + 1));
        end
        idle(15);

        // simultaneous push+pop at level 2 across pointer wrap
        step(1'b1, 8'hB0, 1'b1);
        step(1'b1, 8'hB1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'hB2 + 8'(i), 1'b0);
            chk("t4.level",  32'(if0.level),  32'd2);
            chk("t4.enable", 32'(if0.enable), 32'd1);
            chk("t4.data",   32'(if0.data),   32'hB0 + 32'(i));
        end
        idle(15);

        // asynchronous reset mid-stream
        step(1'b1, 8'hC0, 1'b1);
        step(1'b1, 8'hC1, 1'b1);
        step(1'b1, 8'hC2, 1'b1);
        chk("t5.level3", 32'(if0.level), 32'd3);
        step(1'b0, 8'h00, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t5.enable", 32'(if0.enable), 32'd0);
        chk("t5.data",   32'(if0.data),   32'd0);
        chk("t5.level",  32'(if0.level),  32'd0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("t5.no_stale", 32'(if0.enable), 32'd0);
        end

`ifdef REGISTER_FEED_OVF_EN
        for (int i = 0; i < 5; i++) step(1'b1, 8'hD0 + 8'(i), 1'b1);
        chk("t6.overflow_set", 32'(if0.overflow), 32'd1);
        idle(15);
        chk("t6.overflow_sticky", 32'(if0.overflow), 32'd1);
        @(negedge clk) reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6.overflow_clr", 32'(if0.overflow), 32'd0);
        @(negedge clk) reset_n = 1'b1;
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3);
        idle(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
